// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, FSM state
// codes, ALU/mux select values and the control word driven into the datapath.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [3:0] ST_FETCH      = 4'd0;
  localparam logic [3:0] ST_DECODE     = 4'd1;
  localparam logic [3:0] ST_MEM_ADDR   = 4'd2;
  localparam logic [3:0] ST_MEM_READ   = 4'd3;
  localparam logic [3:0] ST_MEM_WB     = 4'd4;
  localparam logic [3:0] ST_MEM_WRITE  = 4'd5;
  localparam logic [3:0] ST_EXECUTE    = 4'd6;
  localparam logic [3:0] ST_R_COMPLETE = 4'd7;
  localparam logic [3:0] ST_BRANCH     = 4'd8;
  localparam logic [3:0] ST_JUMP       = 4'd9;
  localparam logic [3:0] ST_ADDI_EXEC  = 4'd10;
  localparam logic [3:0] ST_ADDI_WB    = 4'd11;

  // alu_op values, shared with alu_control
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic       reg_dst;
    logic       illegal_op;
  } ctrl_word_t;

  function automatic logic op_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational state-to-control-word decoder. Moore outputs, except that
// the FETCH write strobes follow mem_ready and illegal_op looks at opcode.
module mc_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  logic [3:0]  state,
  input  logic [5:0]  opcode,
  input  logic        mem_ready,
  output ctrl_word_t  ctrl
);

  // Decode one control word per state; anything unlisted stays 0
  always_comb begin
    ctrl = '0;
    case (state)
      ST_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      ST_DECODE: begin
        ctrl.alu_src_b  = SRCB_IMM_SH;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.illegal_op = ~op_supported(opcode);
      end
      ST_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      ST_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      ST_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      ST_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      ST_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      ST_R_COMPLETE: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      ST_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      ST_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      ST_ADDI_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      ST_ADDI_WB: begin
        ctrl.reg_write = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_main_control.sv
// Multicycle MIPS main control FSM: state register and next-state logic,
// with the control word produced by mc_ctrl_decode.
//
//  state        | meaning
//  FETCH      0 | read instruction at PC, PC += 4 when memory is ready
//  DECODE     1 | register read, branch target into ALUOut
//  MEM_ADDR   2 | lw/sw effective address
//  MEM_READ   3 | data read, waits for mem_ready
//  MEM_WB     4 | MDR -> rt
//  MEM_WRITE  5 | data write, waits for mem_ready
//  EXECUTE    6 | R-type ALU operation
//  R_COMPLETE 7 | ALUOut -> rd
//  BRANCH     8 | beq compare, conditional PC load
//  JUMP       9 | PC <- jump target
//  ADDI_EXEC 10 | A + immediate
//  ADDI_WB   11 | ALUOut -> rt
//  12..15       | unused, recover to FETCH
module mc_main_control
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic [1:0] pc_source,
  output logic [1:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       illegal_op,
  output logic [3:0] state
);

  logic [3:0] state_q;
  logic [3:0] state_d;
  ctrl_word_t ctrl;

  // Next-state selection
  always_comb begin
    state_d = ST_FETCH;
    case (state_q)
      ST_FETCH:     state_d = mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = ST_MEM_ADDR;
          OP_RTYPE:     state_d = ST_EXECUTE;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_J:         state_d = ST_JUMP;
          OP_ADDI:      state_d = ST_ADDI_EXEC;
          default:      state_d = ST_FETCH;
        endcase
      end
      // IR is frozen outside FETCH, so re-reading opcode here is safe
      ST_MEM_ADDR: begin
        if (opcode == OP_LW)      state_d = ST_MEM_READ;
        else if (opcode == OP_SW) state_d = ST_MEM_WRITE;
        else                      state_d = ST_FETCH;
      end
      ST_MEM_READ:  state_d = mem_ready ? ST_MEM_WB : ST_MEM_READ;
      ST_MEM_WRITE: state_d = mem_ready ? ST_FETCH : ST_MEM_WRITE;
      ST_EXECUTE:   state_d = ST_R_COMPLETE;
      ST_ADDI_EXEC: state_d = ST_ADDI_WB;
      default:      state_d = ST_FETCH;
    endcase
  end

  // State register, asynchronously returned to FETCH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_FETCH;
    else        state_q <= state_d;
  end

  mc_ctrl_decode u_decode (
    .state     (state_q),
    .opcode    (opcode),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  // FETCH strobes follow mem_ready, so they must be masked while in reset
  assign pc_write      = ctrl.pc_write & rst_n;
  assign ir_write      = ctrl.ir_write & rst_n;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign i_or_d        = ctrl.i_or_d;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign pc_source     = ctrl.pc_source;
  assign alu_op        = ctrl.alu_op;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign reg_write     = ctrl.reg_write;
  assign reg_dst       = ctrl.reg_dst;
  assign illegal_op    = ctrl.illegal_op;
  assign state         = state_q;

endmodule

// File: doc/mc_main_control.md
Name: mc_main_control

Overview:
- Multicycle main control FSM for the MIPS datapath. Drives the 2-bit alu_op that alu_control decodes, together with every other datapath enable and mux select.
- Steps each instruction through fetch, decode, execute, memory and writeback states.
- Stalls in memory states until memory signals ready.
- Unsupported opcodes return to fetch and flag an error.

Parameters:
- OP_RTYPE, 6'b000000, R-type opcode
- OP_LW, 6'b100011, load word opcode
- OP_SW, 6'b101011, store word opcode
- OP_BEQ, 6'b000100, branch-equal opcode
- OP_J, 6'b000010, jump opcode
- OP_ADDI, 6'b001000, add-immediate opcode

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- opcode  input  6  instruction[31:26], from the instruction register
- mem_ready  input  1  memory completes the current access this cycle
- pc_write  output  1  unconditional PC load
- pc_write_cond  output  1  PC load qualified by ALU zero (beq)
- i_or_d  output  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  output  1  memory read strobe
- mem_write  output  1  memory write strobe
- ir_write  output  1  instruction register load
- mem_to_reg  output  1  writeback select: 0 = ALUOut, 1 = MDR
- pc_source  output  2  00 = ALU, 01 = ALUOut, 10 = jump target
- alu_op  output  2  00 = add, 01 = subtract, 10 = decode funct (consumed by alu_control)
- alu_src_a  output  1  0 = PC, 1 = register A
- alu_src_b  output  2  00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2
- reg_write  output  1  register file write enable
- reg_dst  output  1  destination select: 0 = rt, 1 = rd
- illegal_op  output  1  one-cycle pulse in DECODE on an unsupported opcode
- state  output  4  current state, for debug

Behaviour:
- Reset (rst_n low, asynchronous): state = FETCH immediately.
  - pc_write and ir_write are forced to 0 while rst_n is low.
  - Every other output takes its FETCH value.
- State encoding:
  - FETCH = 0, DECODE = 1, MEM_ADDR = 2, MEM_READ = 3, MEM_WB = 4, MEM_WRITE = 5
  - EXECUTE = 6, R_COMPLETE = 7, BRANCH = 8, JUMP = 9, ADDI_EXEC = 10, ADDI_WB = 11
  - Codes 12-15 are unused; if reached, go to FETCH on the next edge.
- Outputs are Moore, decoded from state. Exception: pc_write and ir_write in FETCH are gated by mem_ready. Any output not listed for a state is 0.
- FETCH:
  - mem_read = 1, i_or_d = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00, pc_source = 00.
  - ir_write = pc_write = mem_ready.
  - Holds while mem_ready = 0; goes to DECODE when mem_ready = 1.
- DECODE (computes the branch target):
  - alu_src_a = 0, alu_src_b = 11, alu_op = 00.
  - Next state by opcode:
    - lw or sw -> MEM_ADDR
    - R-type -> EXECUTE
    - beq -> BRANCH
    - j -> JUMP
    - addi -> ADDI_EXEC
    - any other opcode -> FETCH, with illegal_op = 1 for this cycle only.
- MEM_ADDR:
  - alu_src_a = 1, alu_src_b = 10, alu_op = 00.
  - Goes to MEM_READ for lw, MEM_WRITE for sw.
  - opcode is re-sampled here; the IR is stable because ir_write = 0 outside FETCH.
- MEM_READ: mem_read = 1, i_or_d = 1. Holds until mem_ready = 1, then goes to MEM_WB.
- MEM_WB: reg_write = 1, mem_to_reg = 1, reg_dst = 0. Goes to FETCH.
- MEM_WRITE: mem_write = 1, i_or_d = 1. Holds until mem_ready = 1, then goes to FETCH.
- EXECUTE: alu_src_a = 1, alu_src_b = 00, alu_op = 10. Goes to R_COMPLETE.
- R_COMPLETE: reg_write = 1, reg_dst = 1, mem_to_reg = 0. Goes to FETCH.
- BRANCH: alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_write_cond = 1, pc_source = 01. Goes to FETCH.
- JUMP: pc_write = 1, pc_source = 10. Goes to FETCH.
- ADDI_EXEC: alu_src_a = 1, alu_src_b = 10, alu_op = 00. Goes to ADDI_WB.
- ADDI_WB: reg_write = 1, reg_dst = 0, mem_to_reg = 0. Goes to FETCH.
- Instruction latency with mem_ready tied high:
  - lw = 5 cycles
  - sw, R-type, addi = 4 cycles
  - beq, j = 3 cycles
  - Each stall cycle adds 1.
- mem_ready is ignored outside FETCH, MEM_READ and MEM_WRITE.
- Reset asserted mid-instruction: the FSM aborts to FETCH with no further write strobes. mem_write and reg_write drop in the same cycle that rst_n falls.
- Never asserted together in any state: mem_read and mem_write; reg_write and mem_write.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - opcode constants
  - state encodings
  - alu_op encodings (ALUOP_ADD = 2'b00, ALUOP_SUB = 2'b01, ALUOP_FUNCT = 2'b10)
  - alu_src_b and pc_source encodings
- alu_control uses the same alu_op constants.
- Sub-module mc_ctrl_decode is natural: a purely combinational state-to-control-word decoder. The top level keeps only the state register and next-state logic.

Test Plan:
1. Reset, then release with mem_ready = 1 and opcode = 100011 (lw): states 0, 1, 2, 3, 4, 0.
   - MEM_WB: reg_write = 1, mem_to_reg = 1.
   - MEM_ADDR: alu_op = 00, alu_src_b = 10.
2. opcode = 000000 (R-type), mem_ready = 1: states 0, 1, 6, 7, 0.
   - EXECUTE: alu_op = 10.
   - R_COMPLETE: reg_dst = 1, reg_write = 1.
3. opcode = 000100 (beq): BRANCH shows alu_op = 01, pc_write_cond = 1, pc_source = 01. Back in FETCH after 3 cycles.
4. sw with mem_ready low for 3 cycles in MEM_WRITE: mem_write = 1 for 4 cycles total; FETCH follows the mem_ready = 1 cycle.
5. Stall in FETCH: mem_ready = 0 for 2 cycles gives pc_write = ir_write = 0 and state = 0. With mem_ready = 1: a single-cycle pc_write pulse, then DECODE.
6. opcode = 111111 in DECODE: illegal_op = 1 for exactly 1 cycle, then FETCH.
   - Also: drop rst_n during MEM_WB; reg_write goes to 0 asynchronously and state = 0.
